nbit_logic_unit_seq: RTL



---
 rtl/nbit_logic_pkg.sv | 19 +
 rtl/nbit_logic_slice.sv | 28 ++
 rtl/nbit_logic_unit_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/nbit_logic_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential N-bit logic unit.
package nbit_logic_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nbit_logic_slice.sv
// Combinational W-bit bitwise operation unit; one slice of the sequential logic unit.
module nbit_logic_slice
  import nbit_logic_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      OP_PASS: y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/nbit_logic_unit_seq.sv
// Multi-cycle N-bit logic unit: CHUNK bits per BUSY cycle, result held behind valid/ready.
// Optional zero_flag output enabled by defining NBIT_LOGIC_ZERO_FLAG_EN.
module nbit_logic_unit_seq
  import nbit_logic_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op_sel,
  input  logic [N-1:0] in1_val,
  input  logic [N-1:0] in2_val,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_val
`ifdef NBIT_LOGIC_ZERO_FLAG_EN
  ,
  output logic         zero_flag
`endif
);

  localparam int NCH   = N / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  if ((CHUNK < 1) || (CHUNK > N) || ((N % CHUNK) != 0)) begin : g_param_err
    $error("nbit_logic_unit_seq: N must be a multiple of CHUNK and 1 <= CHUNK <= N");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [N-1:0]     res_q, res_d;
  logic [CHUNK-1:0] a_sl, b_sl, y_sl;

`ifdef NBIT_LOGIC_ZERO_FLAG_EN
  logic zero_q, zero_d;
  assign zero_flag = zero_q;
`endif

  assign a_sl = a_q[int'(idx_q) * CHUNK +: CHUNK];
  assign b_sl = b_q[int'(idx_q) * CHUNK +: CHUNK];

  nbit_logic_slice #(.W(CHUNK)) u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .op (op_q),
    .y  (y_sl)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_val   = res_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
`ifdef NBIT_LOGIC_ZERO_FLAG_EN
    zero_d  = zero_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in1_val;
          b_d     = in2_val;
          op_d    = op_sel;
          idx_d   = '0;
          state_d = ST_BUSY;
`ifdef NBIT_LOGIC_ZERO_FLAG_EN
          zero_d  = 1'b1;
`endif
        end
      end
      ST_BUSY: begin
        res_d[int'(idx_q) * CHUNK +: CHUNK] = y_sl;
`ifdef NBIT_LOGIC_ZERO_FLAG_EN
        // Folded one slice at a time so the flag never needs a full-width reduction.
        zero_d = zero_q & ~(|y_sl);
`endif
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
`ifdef NBIT_LOGIC_ZERO_FLAG_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
`ifdef NBIT_LOGIC_ZERO_FLAG_EN
      zero_q  <= zero_d;
`endif
    end
  end

endmodule
